// File: rtl/prism_cfg_sequencer.sv
// Purpose : streams configuration words into PRISM's debug write port under debug
//           reset and shares that port with host register writes when idle.
// Latency : 1 cycle from an accepted host write or config word to dbg_wr; backpressure:
//           host_ready drops while a load runs, cfg_valid low stalls a load indefinitely.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   host_addr/host_wdata/host_wr     host write request, accepted on host_wr & host_ready
//   host_ready                       high only in IDLE with no cfg_start this cycle
//   cfg_start/cfg_base/cfg_count/cfg_autorun   load request and its parameters
//   cfg_abort                        abandons a load in HOLD_RST or LOAD
//   cfg_wdata/cfg_valid/cfg_ready    config word stream
//   dbg_addr/dbg_wdata/dbg_wr        PRISM debug write port (registered)
//   prism_reset/prism_enable         PRISM debug_reset / fsm_enable (registered)
//   busy/done/aborted                status: busy, completion pulse, sticky abort flag
module prism_cfg_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 5,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_wr,
    output logic              host_ready,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_autorun,
    input  logic              cfg_abort,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_wr,
    output logic              prism_reset,
    output logic              prism_enable,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int TMR_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD_RST = 3'd1,
        S_LOAD     = 3'd2,
        S_RELEASE  = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              autorun_q, autorun_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic [DATA_W-1:0] dbg_wdata_q, dbg_wdata_d;
    logic              dbg_wr_q, dbg_wr_d;
    logic              prism_reset_q, prism_reset_d;
    logic              prism_enable_q, prism_enable_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    // A start request in the same cycle steals the port from the host.
    assign host_ready = (state_q == S_IDLE) && !cfg_start;
    // An abort wins over the word offered in the same cycle.
    assign cfg_ready  = (state_q == S_LOAD) && !cfg_abort;
    assign busy       = (state_q != S_IDLE);

    assign dbg_addr     = dbg_addr_q;
    assign dbg_wdata    = dbg_wdata_q;
    assign dbg_wr       = dbg_wr_q;
    assign prism_reset  = prism_reset_q;
    assign prism_enable = prism_enable_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        autorun_d      = autorun_q;
        dbg_addr_d     = dbg_addr_q;
        dbg_wdata_d    = dbg_wdata_q;
        dbg_wr_d       = 1'b0;
        prism_reset_d  = prism_reset_q;
        prism_enable_d = prism_enable_q;
        done_d         = 1'b0;
        aborted_d      = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    addr_d         = cfg_base;
                    cnt_d          = cfg_count;
                    autorun_d      = cfg_autorun;
                    aborted_d      = 1'b0;
                    prism_enable_d = 1'b0;
                    prism_reset_d  = 1'b1;
                    timer_d        = TMR_W'(RST_CYCLES);
                    state_d        = S_HOLD_RST;
                end else if (host_wr) begin
                    dbg_wr_d    = 1'b1;
                    dbg_addr_d  = host_addr;
                    dbg_wdata_d = host_wdata;
                end
            end

            S_HOLD_RST: begin
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                    // Leave once the decremented timer has reached 1. Together with the
                    // start cycle and the first LOAD/RELEASE cycle this keeps
                    // prism_reset asserted RST_CYCLES cycles before the first write.
                    if ({1'b0, timer_q} <= (TMR_W + 1)'(2)) begin
                        state_d = (cnt_q != '0) ? S_LOAD : S_RELEASE;
                    end
                end
            end

            S_LOAD: begin
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cfg_valid) begin
                    dbg_wr_d    = 1'b1;
                    dbg_addr_d  = addr_q;
                    dbg_wdata_d = cfg_wdata;
                    // Byte addressing of 32-bit words; wraps at the top of the window.
                    addr_d      = addr_q + ADDR_W'(4);
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RELEASE;
                    end
                end
            end

            S_RELEASE: begin
                prism_reset_d = 1'b0;
                state_d       = S_FINISH;
            end

            S_FINISH: begin
                prism_enable_d = autorun_q;
                done_d         = 1'b1;
                state_d        = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            cnt_q          <= '0;
            addr_q         <= '0;
            autorun_q      <= 1'b0;
            dbg_addr_q     <= '0;
            dbg_wdata_q    <= '0;
            dbg_wr_q       <= 1'b0;
            prism_reset_q  <= 1'b0;
            prism_enable_q <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            autorun_q      <= autorun_d;
            dbg_addr_q     <= dbg_addr_d;
            dbg_wdata_q    <= dbg_wdata_d;
            dbg_wr_q       <= dbg_wr_d;
            prism_reset_q  <= prism_reset_d;
            prism_enable_q <= prism_enable_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Purpose : self-checking bench for prism_cfg_sequencer with a transaction-level model.
// Latency : model predicts every registered output one edge after the inputs it sees.
// Backpressure: exercised through cfg_valid gaps and host writes held across loads.
module tb_prism_cfg_sequencer;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 5;
    localparam int RST_CYCLES = 2;
    // Cycles spent waiting after the start edge before the first word can be taken.
    localparam int HOLD_CYC   = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_wr;
    logic              host_ready;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base;
    logic [CNT_W-1:0]  cfg_count;
    logic              cfg_autorun;
    logic              cfg_abort;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_wr;
    logic              prism_reset;
    logic              prism_enable;
    logic              busy;
    logic              done;
    logic              aborted;

    prism_cfg_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_wr(host_wr),
        .host_ready(host_ready),
        .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_count(cfg_count),
        .cfg_autorun(cfg_autorun), .cfg_abort(cfg_abort),
        .cfg_wdata(cfg_wdata), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wr(dbg_wr),
        .prism_reset(prism_reset), .prism_enable(prism_enable),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          model_ok = 0;
    bit          m_busy;
    int          m_hold;       // wait cycles still to go before words may flow
    int          m_left;       // words still to be written
    int          m_post;       // 2: reset release pending, 1: completion pending
    logic [5:0]  m_addr;
    bit          m_auto;
    bit          e_wr, e_reset, e_enable, e_done, e_aborted;
    logic [5:0]  e_addr;
    logic [31:0] e_data;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("mdl_host_ready", host_ready, !m_busy && !cfg_start);
            chk("mdl_cfg_ready", cfg_ready,
                m_busy && m_hold == 0 && m_post == 0 && m_left > 0 && !cfg_abort);
            chk("mdl_busy", busy, m_busy);
            chk("mdl_dbg_wr", dbg_wr, e_wr);
            if (e_wr) begin
                chk("mdl_dbg_addr", dbg_addr, e_addr);
                chk("mdl_dbg_wdata", dbg_wdata, e_data);
            end
            chk("mdl_prism_reset", prism_reset, e_reset);
            chk("mdl_prism_enable", prism_enable, e_enable);
            chk("mdl_done", done, e_done);
            chk("mdl_aborted", aborted, e_aborted);
        end
        // Predict what the coming rising edge produces from the inputs now stable.
        if (!rst_n) begin
            m_busy = 0; m_hold = 0; m_left = 0; m_post = 0; m_addr = '0; m_auto = 0;
            e_wr = 0; e_reset = 0; e_enable = 0; e_done = 0; e_aborted = 0;
            e_addr = '0; e_data = '0;
            model_ok = 1;
        end else begin
            e_wr = 0;
            e_done = 0;
            if (!m_busy) begin
                if (cfg_start) begin
                    m_busy = 1; m_hold = HOLD_CYC; m_left = int'(cfg_count); m_post = 0;
                    m_addr = cfg_base; m_auto = cfg_autorun;
                    e_aborted = 0; e_enable = 0; e_reset = 1;
                end else if (host_wr) begin
                    e_wr = 1; e_addr = host_addr; e_data = host_wdata;
                end
            end else if (m_hold > 0 || (m_post == 0 && m_left > 0)) begin
                if (cfg_abort) begin
                    m_busy = 0; m_hold = 0; m_post = 0; e_aborted = 1;
                end else if (m_hold > 0) begin
                    m_hold--;
                    if (m_hold == 0 && m_left == 0) m_post = 2;
                end else if (cfg_valid) begin
                    e_wr = 1; e_addr = m_addr; e_data = cfg_wdata;
                    m_addr = m_addr + 6'd4;
                    m_left--;
                    if (m_left == 0) m_post = 2;
                end
            end else if (m_post == 2) begin
                e_reset = 0; m_post = 1;
            end else begin
                e_enable = m_auto; e_done = 1; m_busy = 0; m_post = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int          n_wr, rst_hi, host_in_load;
    bit          saw_done, en_at_done, rst_at_done;
    logic [5:0]  cap_addr [8];
    logic [5:0]  held_addr;
    logic [31:0] held_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [31:0] d);
        host_wr = 1; host_addr = a; host_wdata = d;
        tick();
        host_wr = 0;
    endtask

    task automatic run_load(input logic [5:0] base, input logic [4:0] cnt, input bit autorun,
                            input int gap, input int abort_after, input bit hold_host);
        int sent = 0;
        int gap_left = 0;
        bit acc;
        bit fin = 0;
        n_wr = 0; rst_hi = 0; host_in_load = 0;
        saw_done = 0; en_at_done = 0; rst_at_done = 1;
        cfg_start = 1; cfg_base = base; cfg_count = cnt; cfg_autorun = autorun;
        cfg_valid = 1; cfg_wdata = $urandom;
        if (hold_host) begin
            held_addr = 6'($urandom); held_data = $urandom;
            host_wr = 1; host_addr = held_addr; host_wdata = held_data;
        end
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc > 0 && dbg_wr) begin
                if (n_wr < 8) cap_addr[n_wr] = dbg_addr;
                n_wr++;
            end
            if (cyc > 0 && prism_reset && n_wr == 0) rst_hi++;
            if (done) begin
                saw_done = 1; en_at_done = prism_enable; rst_at_done = prism_reset;
            end
            if (host_wr && host_ready && (cyc == 0 || busy)) host_in_load++;
            if (cyc > 0 && !busy) begin
                fin = 1;
            end else begin
                acc = cfg_valid && cfg_ready;
                tick();
                cfg_start = 0;
                cfg_abort = 0;
                if (acc) begin
                    sent++;
                    cfg_wdata = $urandom;
                    if (gap > 0) begin
                        cfg_valid = 0; gap_left = gap;
                    end
                    if (sent == abort_after) cfg_abort = 1;
                end else if (gap_left > 0) begin
                    gap_left--;
                    if (gap_left == 0) cfg_valid = 1;
                end
            end
        end
        chk("load_terminates", fin, 1);
        cfg_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; host_addr = '0; host_wdata = '0; host_wr = 0;
        cfg_start = 0; cfg_base = '0; cfg_count = '0; cfg_autorun = 0; cfg_abort = 0;
        cfg_wdata = '0; cfg_valid = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_host_ready", host_ready, 1);
        chk("rst_dbg_wr", dbg_wr, 0);
        chk("rst_prism_reset", prism_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aborted", aborted, 0);
        tick();
        rst_n = 1;
        tick();

        // Host pass-through.
        host_wr = 1; host_addr = 6'h18; host_wdata = 32'h0000_03A5;
        @(negedge clk);
        chk("pt_host_ready", host_ready, 1);
        tick();
        host_wr = 0;
        @(negedge clk);
        chk("pt_dbg_wr", dbg_wr, 1);
        chk("pt_dbg_addr", dbg_addr, 32'h18);
        chk("pt_dbg_wdata", dbg_wdata, 32'h3A5);
        chk("pt_busy", busy, 0);
        tick();

        // Three words from 0x3C with wrap and autorun.
        run_load(6'h3C, 5'd3, 1, 0, -1, 0);
        chk("l3_nwr", n_wr, 3);
        chk("l3_addr0", cap_addr[0], 32'h3C);
        chk("l3_addr1", cap_addr[1], 32'h00);
        chk("l3_addr2", cap_addr[2], 32'h04);
        chk("l3_rst_cycles", rst_hi, 2);
        chk("l3_done", saw_done, 1);
        chk("l3_enable_at_done", en_at_done, 1);
        chk("l3_reset_at_done", rst_at_done, 0);
        tick();

        // Back-pressure with a host write held throughout.
        run_load(6'h10, 5'd2, 0, 5, -1, 1);
        chk("bp_nwr", n_wr, 2);
        chk("bp_host_in_load", host_in_load, 0);
        chk("bp_host_ready_after", host_ready, 1);
        tick();
        host_wr = 0;
        @(negedge clk);
        chk("bp_host_wr_issued", dbg_wr, 1);
        chk("bp_host_addr", dbg_addr, held_addr);
        tick();

        // Start and host write in the same cycle.
        run_load(6'h20, 5'd2, 1, 0, -1, 1);
        chk("sim_host_in_load", host_in_load, 0);
        chk("sim_done", saw_done, 1);
        tick();
        host_wr = 0;
        @(negedge clk);
        chk("sim_host_after_done", dbg_wr, 1);
        chk("sim_host_data", dbg_wdata, held_data);
        tick();

        // Abort after the first of four words.
        run_load(6'h08, 5'd4, 1, 0, 1, 0);
        chk("ab_nwr", n_wr, 1);
        chk("ab_no_done", saw_done, 0);
        chk("ab_aborted", aborted, 1);
        chk("ab_prism_reset", prism_reset, 1);
        chk("ab_prism_enable", prism_enable, 0);
        tick();

        // Empty load clears the abort flag and still pulses reset.
        run_load(6'h00, 5'd0, 0, 0, -1, 0);
        chk("c0_nwr", n_wr, 0);
        chk("c0_rst_cycles", rst_hi, 2);
        chk("c0_done", saw_done, 1);
        chk("c0_enable", en_at_done, 0);
        chk("c0_aborted_cleared", aborted, 0);
        tick();

        // Synchronous reset in the middle of a load.
        cfg_start = 1; cfg_base = 6'h04; cfg_count = 5'd5; cfg_autorun = 1;
        cfg_valid = 1; cfg_wdata = $urandom;
        tick();
        cfg_start = 0;
        repeat (2) tick();
        rst_n = 0;
        tick();
        @(negedge clk);
        chk("mr_dbg_wr", dbg_wr, 0);
        chk("mr_dbg_addr", dbg_addr, 0);
        chk("mr_dbg_wdata", dbg_wdata, 0);
        chk("mr_prism_reset", prism_reset, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cfg_ready", cfg_ready, 0);
        tick();
        rst_n = 1;
        cfg_valid = 0;
        repeat (2) tick();

        // Randomized traffic checked by the model.
        for (int it = 0; it < 30; it++) begin
            int nh;
            int cnt;
            nh = $urandom_range(0, 3);
            for (int h = 0; h < nh; h++) begin
                host_write(6'($urandom), $urandom);
                if ($urandom_range(0, 1) == 1) tick();
            end
            cnt = $urandom_range(0, 6);
            run_load(6'($urandom), 5'(cnt), 1'($urandom), $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1,
                     1'($urandom_range(0, 3) == 0));
            host_wr = 0;
            tick();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
